// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//
// Purpose:
//   Serialises one 8-bit byte per request onto uart_tx as an asynchronous
//   frame: start bit, 8 data bits LSB first, optional even-parity bit,
//   then STOP_BITS stop bits. Each bit lasts BAUD_DIV = CLOCK_FREQ / BAUD
//   clock cycles (integer truncation).
//
// Configuration:
//   UART_TX_PARITY_EN  - when defined, an even-parity bit is inserted between
//                        the last data bit and the stop bit(s) (8E1 / 8E2).
//                        When undefined, no parity state or logic exists.
//
// Parameters:
//   CLOCK_FREQ  system clock frequency in Hz
//   BAUD        line rate in bit/s
//   STOP_BITS   number of stop bits, 1 or 2
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   synchronous reset, active-high
//   Send_En  in   transmit request, only looked at while idle
//   Data     in   byte to send, captured when Send_En is accepted
//   uart_tx  out  serial line, registered, idles high
//   Tx_Done  out  one-cycle pulse in the first idle cycle after a frame
//   Tx_Busy  out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Send_En,
  input  logic [7:0] Data,
  output logic       uart_tx,
  output logic       Tx_Done,
  output logic       Tx_Busy
);

  localparam int BAUD_DIV = CLOCK_FREQ / BAUD;
  // Keep at least one bit of counter so BAUD_DIV == 1 still elaborates.
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_done;
  logic             r_busy;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic w_bit_end;

  // Last cycle of the current bit period.
  assign w_bit_end = (r_baud_cnt == CNT_LAST);

  assign uart_tx = r_tx;
  assign Tx_Done = r_done;
  assign Tx_Busy = r_busy;

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = here would let later statements see
  // half-updated state and the simulated behaviour would stop matching silicon.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: r_shift (and r_parity) are data-path registers that are always
      // reloaded before use, so they are deliberately left out of the reset.
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          if (Send_En) begin
            r_shift <= Data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^Data;
`endif
            r_tx    <= 1'b0;          // start bit appears the next cycle
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == STOP_LAST) begin
              // Done is seen together with the first idle cycle, busy already low,
              // so a requester can chain the next byte on the Done cycle.
              r_bit_idx <= '0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_tx
//
// Self-checking bench for uart_byte_tx at default parameters (BAUD_DIV = 434).
// The reference model builds each frame as a list of line levels (start, data
// LSB first, optional parity, stop bits) and expects the line to sit at level
// n for cycles n*BAUD_DIV .. (n+1)*BAUD_DIV-1 after the first start-bit cycle.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_byte_tx;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD       = 115200;
  localparam int STOP_BITS  = 1;
  localparam int DIV        = CLOCK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS      = 1;
`else
  localparam int PBITS      = 0;
`endif
  localparam int FRAME_LEN  = (1 + 8 + PBITS + STOP_BITS) * DIV;

  typedef bit bitq_t[$];

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Send_En = 1'b0;
  logic [7:0] Data = 8'h00;
  logic       uart_tx;
  logic       Tx_Done;
  logic       Tx_Busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic g_par;

  uart_byte_tx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD      (BAUD),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Send_En(Send_En),
    .Data   (Data),
    .uart_tx(uart_tx),
    .Tx_Done(Tx_Done),
    .Tx_Busy(Tx_Busy)
  );

  always #5 Clk = ~Clk;

  // Line levels of one frame, one entry per bit period.
  function automatic bitq_t frame_bits(input logic [7:0] b);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (PBITS == 1) q.push_back(^b);
    for (int i = 0; i < STOP_BITS; i++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic tally(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Request one byte; returns at the falling edge of the first start-bit cycle.
  task automatic send_byte(input logic [7:0] b, input bit keep_en);
    Data    = b;
    Send_En = 1'b1;
    @(negedge Clk);
    Send_En = keep_en;
  endtask

  // Called at the falling edge of the first start-bit cycle. Checks every
  // cycle of the frame against the model, decodes the byte at mid-bit, and
  // checks the Done cycle. With chain set, requests nxt on the Done cycle.
  // poke_cycle >= 0 raises Send_En with poke_data for one cycle mid-frame.
  task automatic check_frame(input logic [7:0] b, input bit chain, input logic [7:0] nxt,
                             input bit keep_en, input int poke_cycle,
                             input logic [7:0] poke_data, input string name);
    bitq_t q;
    int len, slot_bad, bad_busy, bad_done;
    logic first_val;
    logic [7:0] dec;
    q = frame_bits(b);
    len = q.size() * DIV;
    slot_bad = 0; bad_busy = 0; bad_done = 0; dec = '0; first_val = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k == poke_cycle) begin
        Data    = poke_data;
        Send_En = 1'b1;
      end
      if (poke_cycle >= 0 && k == poke_cycle + 1) Send_En = keep_en;
      if (uart_tx !== q[k / DIV]) begin
        if (slot_bad == 0) first_val = uart_tx;
        slot_bad++;
      end
      if (Tx_Busy !== 1'b1) bad_busy++;
      if (Tx_Done !== 1'b0) bad_done++;
      if (k / DIV >= 1 && k / DIV <= 8 && k % DIV == DIV / 2) dec[k / DIV - 1] = uart_tx;
      if (PBITS == 1 && k / DIV == 9 && k % DIV == DIV / 2) g_par = uart_tx;
      if (k % DIV == DIV - 1) begin
        n_checks++;
        if (slot_bad == 0) n_pass++;
        else $display("FAIL %s bit slot %0d: uart_tx wrong in %0d cycles (first %b), required %b",
                      name, k / DIV, slot_bad, first_val, q[k / DIV]);
        slot_bad = 0;
      end
      @(negedge Clk);
    end
    tally(bad_busy == 0, {name, " busy high during frame (bad cycles)"}, bad_busy, 0);
    tally(bad_done == 0, {name, " no early Tx_Done (bad cycles)"}, bad_done, 0);
    tally(dec === b, {name, " decoded byte"}, int'(dec), int'(b));
    tally(Tx_Done === 1'b1, {name, " Tx_Done on first idle cycle"}, int'(Tx_Done), 1);
    tally(Tx_Busy === 1'b0, {name, " Tx_Busy low on Done cycle"}, int'(Tx_Busy), 0);
    tally(uart_tx === 1'b1, {name, " line high on Done cycle"}, int'(uart_tx), 1);
    if (chain) begin
      Data    = nxt;
      Send_En = 1'b1;
      @(negedge Clk);
      Send_En = keep_en;
    end else begin
      @(negedge Clk);
      tally(Tx_Done === 1'b0, {name, " Tx_Done is one cycle"}, int'(Tx_Done), 0);
    end
  endtask

  // Watch an idle line for n cycles.
  task automatic check_idle(input int n, input string name);
    int bad_tx, bad_busy, bad_done;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int k = 0; k < n; k++) begin
      if (uart_tx !== 1'b1) bad_tx++;
      if (Tx_Busy !== 1'b0) bad_busy++;
      if (Tx_Done !== 1'b0) bad_done++;
      @(negedge Clk);
    end
    tally(bad_tx == 0, {name, " line high (bad cycles)"}, bad_tx, 0);
    tally(bad_busy == 0, {name, " busy low (bad cycles)"}, bad_busy, 0);
    tally(bad_done == 0, {name, " no Tx_Done (bad cycles)"}, bad_done, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    tally(uart_tx === 1'b1, "reset uart_tx", int'(uart_tx), 1);
    tally(Tx_Busy === 1'b0, "reset Tx_Busy", int'(Tx_Busy), 0);
    tally(Tx_Done === 1'b0, "reset Tx_Done", int'(Tx_Done), 0);
    Reset = 1'b0;
    check_idle(1000, "post-reset idle");
  endtask

  task automatic test_single_frame();
    send_byte(8'h55, 1'b0);
    check_frame(8'h55, 1'b0, 8'h00, 1'b0, -1, 8'h00, "single 0x55");
  endtask

  task automatic test_back_to_back();
    send_byte(8'h3C, 1'b0);
    check_frame(8'h3C, 1'b1, 8'hA3, 1'b0, -1, 8'h00, "b2b first 0x3C");
    check_frame(8'hA3, 1'b0, 8'h00, 1'b0, -1, 8'h00, "b2b second 0xA3");
  endtask

  task automatic test_busy_rejection();
    send_byte(8'h12, 1'b0);
    check_frame(8'h12, 1'b0, 8'h00, 1'b0, 1000, 8'hFF, "busy-reject 0x12");
    check_idle(2 * DIV, "busy-reject no second frame");
  endtask

  task automatic test_mid_frame_reset();
    int bad_done;
    send_byte(8'h5A, 1'b0);
    repeat (4 * DIV + DIV / 2) @(negedge Clk);   // middle of data bit 3
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    tally(uart_tx === 1'b1, "mid-reset uart_tx", int'(uart_tx), 1);
    tally(Tx_Busy === 1'b0, "mid-reset Tx_Busy", int'(Tx_Busy), 0);
    tally(Tx_Done === 1'b0, "mid-reset Tx_Done", int'(Tx_Done), 0);
    check_idle(FRAME_LEN + DIV, "after mid-reset");
    send_byte(8'h81, 1'b0);
    check_frame(8'h81, 1'b0, 8'h00, 1'b0, -1, 8'h00, "after-reset 0x81");
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b0);
      check_frame(b, 1'b0, 8'h00, 1'b0, int'($urandom_range(1, FRAME_LEN - 2)),
                  8'($urandom), $sformatf("random#%0d 0x%02h", i, b));
      repeat ($urandom_range(0, 20)) @(negedge Clk);
    end
  endtask

  task automatic test_held_send_en();
    logic [7:0] d0, d1, d2;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    send_byte(d0, 1'b1);
    // Data changes mid-frame with Send_En still high; re-sampled at next accept.
    check_frame(d0, 1'b1, d1, 1'b1, 700, d1, "held frame0");
    check_frame(d1, 1'b1, d2, 1'b0, -1, 8'h00, "held frame1");
    check_frame(d2, 1'b0, 8'h00, 1'b0, -1, 8'h00, "held frame2");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send_byte(8'hA5, 1'b0);
    check_frame(8'hA5, 1'b0, 8'h00, 1'b0, -1, 8'h00, "parity 0xA5");
    tally(g_par === 1'b0, "parity bit of 0xA5", int'(g_par), 0);
    send_byte(8'h07, 1'b0);
    check_frame(8'h07, 1'b0, 8'h00, 1'b0, -1, 8'h00, "parity 0x07");
    tally(g_par === 1'b1, "parity bit of 0x07", int'(g_par), 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_rejection();
    test_mid_frame_reset();
    test_random_frames();
    test_held_send_en();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
